// File: rtl/breadboard_sweeper_pkg.sv
// Shared types and constants for the breadboard sweep sequencer and its result store.
package breadboard_sweeper_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int N_CODES  = 16;
  localparam int ADDR_W   = 4;
  localparam int WORD_W   = 4;
  localparam int CNT_W    = 5;
  localparam int IDX_W    = 5;
  localparam int SETTLE_W = 4;

  // Terminal index value; needs the fifth idx bit so the loop never leans on a 4-bit wrap.
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_CODES);

endpackage

// File: rtl/breadboard_sweeper_sweep_result_store.sv
// 16x4 result flops with synchronous clear, one write port and a registered read port.
module sweep_result_store
  import breadboard_sweeper_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_r [N_CODES];

  // Storage array and read register; a same-cycle read of the write address returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CODES; i++) begin
        mem_r[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      rd_data <= mem_r[rd_addr];
      if (clr) begin
        for (int i = 0; i < N_CODES; i++) begin
          mem_r[i] <= '0;
        end
      end else if (wr_en) begin
        mem_r[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/breadboard_sweeper.sv
// Clocked sequencer that steps the breadboard through all 16 input codes, capturing
// each output word into the result store and counting ones per output.
module breadboard_sweeper
  import breadboard_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              w,
  output logic              x,
  output logic              y,
  output logic              z,
  input  logic              f6,
  input  logic              f7,
  input  logic              f8,
  input  logic              f9,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic [CNT_W-1:0]  cnt6,
  output logic [CNT_W-1:0]  cnt7,
  output logic [CNT_W-1:0]  cnt8,
  output logic [CNT_W-1:0]  cnt9
);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);

  state_t              state_r;
  logic [IDX_W-1:0]    idx_r;
  logic [SETTLE_W-1:0] settle_r;
  logic                clr_s;
  logic                wr_en_s;
  logic [WORD_W-1:0]   wr_data_s;

  // Store control decoded from the current state; clear coincides with an accepted start.
  always_comb begin
    clr_s     = 1'b0;
    wr_en_s   = 1'b0;
    wr_data_s = {f6, f7, f8, f9};
    if (((state_r == S_IDLE) || (state_r == S_DONE)) && start) begin
      clr_s = 1'b1;
    end else begin
      clr_s = 1'b0;
    end
    if (state_r == S_CAPTURE) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Sweep FSM with registered status, drive and ones-count outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      idx_r    <= '0;
      settle_r <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      {w, x, y, z} <= 4'b0000;
      cnt6     <= '0;
      cnt7     <= '0;
      cnt8     <= '0;
      cnt9     <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r <= S_DRIVE;
            idx_r   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            cnt6    <= '0;
            cnt7    <= '0;
            cnt8    <= '0;
            cnt9    <= '0;
          end
        end
        S_DRIVE: begin
          {w, x, y, z} <= idx_r[ADDR_W-1:0];
          settle_r     <= SETTLE_LD;
          state_r      <= (SETTLE_LD == 4'd0) ? S_CAPTURE : S_SETTLE;
        end
        S_SETTLE: begin
          // Counter starts at SETTLE_CYCLES, so leaving on 1 spends exactly that many cycles here.
          if (settle_r <= 4'd1) begin
            state_r <= S_CAPTURE;
          end else begin
            settle_r <= settle_r - 4'd1;
          end
        end
        S_CAPTURE: begin
          cnt6  <= cnt6 + CNT_W'(f6);
          cnt7  <= cnt7 + CNT_W'(f7);
          cnt8  <= cnt8 + CNT_W'(f8);
          cnt9  <= cnt9 + CNT_W'(f9);
          idx_r <= idx_r + 5'd1;
          if ((idx_r + 5'd1) == IDX_END) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= S_DRIVE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  sweep_result_store u_store (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .wr_en   (wr_en_s),
    .wr_addr (idx_r[ADDR_W-1:0]),
    .wr_data (wr_data_s),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Bench for breadboard_sweeper: default-settle and zero-settle instances, each driving a
// behavioural breadboard model; read results pass through an expected-value queue.
module tb_breadboard_sweeper;

  localparam int S_A = 2;
  localparam int S_B = 0;

  logic clk = 1'b0;
  logic rst;

  logic start_a, busy_a, done_a, w_a, x_a, y_a, z_a, f6_a, f7_a, f8_a, f9_a;
  logic [3:0] rd_addr_a, rd_data_a;
  logic [4:0] cnt6_a, cnt7_a, cnt8_a, cnt9_a;

  logic start_b, busy_b, done_b, w_b, x_b, y_b, z_b, f6_b, f7_b, f8_b, f9_b;
  logic [3:0] rd_addr_b, rd_data_b;
  logic [4:0] cnt6_b, cnt7_b, cnt8_b, cnt9_b;

  int checks = 0;
  int errors = 0;

  logic [3:0] rd_q[$];
  logic [3:0] code_q_a[$];
  logic [3:0] code_q_b[$];
  int phase_a = 0;
  int phase_b = 0;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[16];

  always #5 clk = ~clk;

  // Breadboard truth table {f6,f7,f8,f9}; ones per column are 6, 6, 4, 8.
  function automatic logic [3:0] bb(input logic [3:0] c);
    case (c)
      4'd0:  bb = 4'b0000;
      4'd1:  bb = 4'b0001;
      4'd2:  bb = 4'b0101;
      4'd3:  bb = 4'b1110;
      4'd4:  bb = 4'b1001;
      4'd5:  bb = 4'b0100;
      4'd6:  bb = 4'b0111;
      4'd7:  bb = 4'b1001;
      4'd8:  bb = 4'b1001;
      4'd9:  bb = 4'b0001;
      4'd10: bb = 4'b1100;
      4'd11: bb = 4'b0011;
      4'd12: bb = 4'b0100;
      4'd13: bb = 4'b1000;
      4'd14: bb = 4'b0000;
      default: bb = 4'b0010;
    endcase
  endfunction

  assign {f6_a, f7_a, f8_a, f9_a} = bb({w_a, x_a, y_a, z_a});
  assign {f6_b, f7_b, f8_b, f9_b} = bb({w_b, x_b, y_b, z_b});

  breadboard_sweeper #(.SETTLE_CYCLES(S_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .w(w_a), .x(x_a), .y(y_a), .z(z_a),
    .f6(f6_a), .f7(f7_a), .f8(f8_a), .f9(f9_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .cnt6(cnt6_a), .cnt7(cnt7_a), .cnt8(cnt8_a), .cnt9(cnt9_a)
  );

  breadboard_sweeper #(.SETTLE_CYCLES(S_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .w(w_b), .x(x_b), .y(y_b), .z(z_b),
    .f6(f6_b), .f7(f7_b), .f8(f8_b), .f9(f9_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .cnt6(cnt6_b), .cnt7(cnt7_b), .cnt8(cnt8_b), .cnt9(cnt9_b)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Code seen in the CAPTURE slot of each per-code window, checked against the queued sequence.
  always @(negedge clk) begin
    logic [3:0] e;
    if (busy_a) begin
      if (phase_a == S_A + 1) begin
        if (code_q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL code_a: unexpected capture of code %0d", {w_a, x_a, y_a, z_a});
        end else begin
          e = code_q_a.pop_front();
          chk("code_a", {w_a, x_a, y_a, z_a}, e);
        end
        phase_a = 0;
      end else begin
        phase_a++;
      end
    end else begin
      phase_a = 0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (busy_b) begin
      if (phase_b == S_B + 1) begin
        if (code_q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL code_b: unexpected capture of code %0d", {w_b, x_b, y_b, z_b});
        end else begin
          e = code_q_b.pop_front();
          chk("code_b", {w_b, x_b, y_b, z_b}, e);
        end
        phase_b = 0;
      end else begin
        phase_b++;
      end
    end else begin
      phase_b = 0;
    end
  end

  task automatic read_chk(input int which, input logic [3:0] a, input logic [3:0] exp, input string nm);
    logic [3:0] e;
    rd_q.push_back(exp);
    if (which == 0) rd_addr_a = a;
    else rd_addr_b = a;
    @(posedge clk); #1;
    e = rd_q.pop_front();
    chk(nm, (which == 0) ? rd_data_a : rd_data_b, e);
  endtask

  task automatic wait_done(input int which, output int n);
    n = 0;
    while (!((which == 0) ? done_a : done_b) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic push_codes(input int which, input int sweeps);
    for (int s = 0; s < sweeps; s++) begin
      for (int c = 0; c < 16; c++) begin
        if (which == 0) code_q_a.push_back(4'(c));
        else code_q_b.push_back(4'(c));
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    vecs[0]  = '{4'd0,  4'b0000}; vecs[1]  = '{4'd1,  4'b0001};
    vecs[2]  = '{4'd2,  4'b0101}; vecs[3]  = '{4'd3,  4'b1110};
    vecs[4]  = '{4'd4,  4'b1001}; vecs[5]  = '{4'd5,  4'b0100};
    vecs[6]  = '{4'd6,  4'b0111}; vecs[7]  = '{4'd7,  4'b1001};
    vecs[8]  = '{4'd8,  4'b1001}; vecs[9]  = '{4'd9,  4'b0001};
    vecs[10] = '{4'd10, 4'b1100}; vecs[11] = '{4'd11, 4'b0011};
    vecs[12] = '{4'd12, 4'b0100}; vecs[13] = '{4'd13, 4'b1000};
    vecs[14] = '{4'd14, 4'b0000}; vecs[15] = '{4'd15, 4'b0010};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_wxyz_a", {w_a, x_a, y_a, z_a}, 0);
    chk("rst_cnt_a", {cnt6_a, cnt7_a, cnt8_a, cnt9_a}, 0);
    chk("rst_rd_a", rd_data_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    read_chk(0, 4'd5, 4'd0, "rd_after_rst_a");

    // Full sweep with default settle
    push_codes(0, 1);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("busy_after_start_a", busy_a, 1);
    wait_done(0, n);
    chk("sweep_len_a", n, 64);
    chk("busy_at_done_a", busy_a, 0);
    chk("cnt6_a", cnt6_a, 6);
    chk("cnt7_a", cnt7_a, 6);
    chk("cnt8_a", cnt8_a, 4);
    chk("cnt9_a", cnt9_a, 8);
    for (int i = 0; i < 16; i++) begin
      read_chk(0, vecs[i].addr, vecs[i].exp, $sformatf("rd_a_%0d", i));
    end
    chk("codes_left_a", code_q_a.size(), 0);

    // Zero-settle instance
    push_codes(1, 1);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_done(1, n);
    chk("sweep_len_b", n, 32);
    chk("cnt_b", {cnt6_b, cnt7_b, cnt8_b, cnt9_b}, {5'd6, 5'd6, 5'd4, 5'd8});
    for (int i = 0; i < 16; i++) begin
      read_chk(1, vecs[i].addr, vecs[i].exp, $sformatf("rd_b_%0d", i));
    end
    chk("codes_left_b", code_q_b.size(), 0);

    // Start held high across two sweeps
    push_codes(0, 2);
    start_a = 1'b1;
    @(posedge clk); #1;
    chk("held_busy_a", busy_a, 1);
    wait_done(0, n);
    chk("held_len1_a", n, 64);
    @(posedge clk); #1;
    chk("held_done_drop_a", done_a, 0);
    chk("held_busy_again_a", busy_a, 1);
    chk("held_cnt_clear_a", {cnt6_a, cnt7_a, cnt8_a, cnt9_a}, 0);
    wait_done(0, n);
    start_a = 1'b0;
    chk("held_len2_a", n, 64);
    chk("held_cnt_a", {cnt6_a, cnt7_a, cnt8_a, cnt9_a}, {5'd6, 5'd6, 5'd4, 5'd8});
    @(posedge clk); #1;
    chk("done_hold_a", done_a, 1);
    chk("codes_left_held_a", code_q_a.size(), 0);

    // Reset in the middle of a sweep
    push_codes(0, 1);
    rd_addr_a = 4'd3;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rd3_a", rd_data_a, 4'b1110);
    chk("mid_cnt7_a", cnt7_a, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy_a", busy_a, 0);
    chk("mid_rst_wxyz_a", {w_a, x_a, y_a, z_a}, 0);
    chk("mid_rst_cnt_a", {cnt6_a, cnt7_a, cnt8_a, cnt9_a}, 0);
    chk("mid_rst_rd_a", rd_data_a, 0);
    code_q_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    read_chk(0, 4'd3, 4'd0, "post_rst_rd3_a");
    read_chk(0, 4'd2, 4'd0, "post_rst_rd2_a");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
